// File: rtl/simon_sequencer.sv
// Simon game controller: builds an LFSR pattern sequence, plays it on the LEDs
// round by round, then checks each comparator submission against it.
module simon_sequencer #(
    parameter int MAX_ROUNDS     = 8,
    parameter int SHOW_CYCLES    = 25000000,
    parameter int GAP_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       input_done,
    input  logic       input_correct,
    output logic [5:0] number_desired,
    output logic [5:0] display,
    output logic [3:0] round,
    output logic       busy,
    output logic       win,
    output logic       lose
);
    localparam int CMAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CMAX    = (TIMEOUT_CYCLES > CMAX_SG) ? TIMEOUT_CYCLES : CMAX_SG;
    localparam int CNT_W   = $clog2(CMAX + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX  = 4'(MAX_ROUNDS - 1);
    localparam logic [3:0]       MAX_RND   = 4'(MAX_ROUNDS);

    typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_OFF, WAIT, WIN, LOSE} state_t;

    state_t           state, state_d;
    logic [15:0]      lfsr;
    logic             prev_done;
    logic [3:0]       idx, idx_d, round_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [5:0]       seq [16];
    logic             seq_we, win_d, lose_d, busy_d, sub;
    logic [5:0]       pat, seq_rd, display_d, desired_d;

    assign pat = (lfsr[5:0] == 6'd0) ? 6'd1 : lfsr[5:0];
    assign sub = input_done & ~prev_done;
    // Forward a pattern written this cycle so a same-cycle read is never stale.
    assign seq_rd = (seq_we && idx == idx_d) ? pat : seq[idx_d];

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        round_d = round;
        seq_we  = 1'b0;
        win_d   = win;
        lose_d  = lose;
        case (state)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    state_d = GEN;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    round_d = 4'd1;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                end
            end
            GEN: begin
                seq_we = 1'b1;
                cnt_d  = '0;
                if (idx == LAST_IDX) begin
                    state_d = SHOW_ON;
                    idx_d   = 4'd0;
                    round_d = 4'd1;
                end else begin
                    idx_d = idx + 4'd1;
                end
            end
            SHOW_ON: begin
                if (cnt == SHOW_LAST) begin
                    state_d = SHOW_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SHOW_OFF: begin
                if (cnt == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx + 4'd1 == round) begin
                        state_d = WAIT;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = SHOW_ON;
                        idx_d   = idx + 4'd1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT: begin
                // A submission takes priority over a timeout in the same cycle.
                if (sub) begin
                    cnt_d = '0;
                    if (!input_correct) begin
                        state_d = LOSE;
                        lose_d  = 1'b1;
                    end else if (idx + 4'd1 < round) begin
                        idx_d = idx + 4'd1;
                    end else if (round < MAX_RND) begin
                        round_d = round + 4'd1;
                        idx_d   = 4'd0;
                        state_d = SHOW_ON;
                    end else begin
                        state_d = WIN;
                        win_d   = 1'b1;
                    end
                end else if (cnt == TO_LAST) begin
                    state_d = LOSE;
                    lose_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d    = (state_d == GEN) || (state_d == SHOW_ON) ||
                    (state_d == SHOW_OFF) || (state_d == WAIT);
        display_d = 6'd0;
        desired_d = number_desired;
        if (state_d == SHOW_ON) display_d = seq_rd;
        if (state_d == WIN)     display_d = 6'h3F;
        if (state_d == WAIT)    desired_d = seq_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            lfsr           <= 16'hACE1;
            idx            <= 4'd0;
            cnt            <= '0;
            prev_done      <= 1'b0;
            number_desired <= 6'd0;
            display        <= 6'd0;
            round          <= 4'd0;
            busy           <= 1'b0;
            win            <= 1'b0;
            lose           <= 1'b0;
        end else begin
            state          <= state_d;
            lfsr           <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            idx            <= idx_d;
            cnt            <= cnt_d;
            prev_done      <= input_done;
            number_desired <= desired_d;
            display        <= display_d;
            round          <= round_d;
            busy           <= busy_d;
            win            <= win_d;
            lose           <= lose_d;
        end
    end

    always_ff @(posedge clk) begin
        if (seq_we && !reset) seq[idx] <= pat;
    end
endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: LFSR-derived expected patterns, game timeline
// expectations, randomized idle lengths and submission timing.
module tb_simon_sequencer;
    localparam int MR = 3, SHOW = 4, GAP = 2, TO = 20;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic       input_done = 1'b0, input_correct = 1'b0;
    logic [5:0] number_desired, display;
    logic [3:0] round;
    logic       busy, win, lose;
    logic [18:0] outs;

    int total = 0, bad = 0, since_rst = 0;
    logic [5:0] exp_seq [0:MR-1];

    simon_sequencer #(.MAX_ROUNDS(MR), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP),
                      .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .input_done(input_done),
        .input_correct(input_correct), .number_desired(number_desired),
        .display(display), .round(round), .busy(busy), .win(win), .lose(lose));

    assign outs = {number_desired, display, round, busy, win, lose};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) since_rst <= 0;
        else       since_rst <= since_rst + 1;
    end

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] x;
        x = 16'hACE1;
        for (int i = 0; i < n; i++) x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
        return x;
    endfunction

    function automatic logic [5:0] pat_of(input logic [15:0] x);
        return (x[5:0] == 6'd0) ? 6'd1 : x[5:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; input_done = 1'b0; input_correct = 1'b0;
        ticks(2);
        reset = 1'b0;
    endtask

    // The game's patterns are the LFSR states of the three GEN cycles.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < MR; i++) exp_seq[i] = pat_of(lfsr_at(since_rst + i));
    endtask

    task automatic press(input logic ok);
        input_done = 1'b1; input_correct = ok;
        tick();
        input_done = 1'b0; input_correct = 1'b0;
    endtask

    task automatic gen_phase(output int errs);
        errs = 0;
        for (int k = 0; k < MR; k++) begin
            if (busy !== 1'b1 || display !== 6'd0 || round !== 4'd1) errs++;
            tick();
        end
    endtask

    task automatic show_phase(input int r, output int errs);
        errs = 0;
        for (int i = 0; i < r; i++) begin
            for (int k = 0; k < SHOW; k++) begin
                if (display !== exp_seq[i] || busy !== 1'b1 || round !== 4'(r)) errs++;
                tick();
            end
            for (int k = 0; k < GAP; k++) begin
                if (display !== 6'd0 || busy !== 1'b1 || round !== 4'(r)) errs++;
                tick();
            end
        end
        if (busy !== 1'b1 || display !== 6'd0 || round !== 4'(r) ||
            number_desired !== exp_seq[0]) errs++;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            total++;
            if (outs !== 19'd0) begin
                bad++; $display("FAIL reset_idle cyc=%0d outs=%h expected=0", k, outs);
            end
            tick();
        end
    endtask

    task automatic test_first_round();
        int errs;
        do_reset();
        ticks($urandom_range(3, 40));
        pulse_start();
        total++;
        if (busy !== 1'b1 || round !== 4'd1) begin
            bad++; $display("FAIL first_busy busy=%b round=%0d expected busy=1 round=1", busy, round);
        end
        gen_phase(errs);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL first_gen errs=%0d expected 0", errs); end
        show_phase(1, errs);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL first_show errs=%0d expected 0", errs); end
        total++;
        if (number_desired !== exp_seq[0] || round !== 4'd1 || win !== 1'b0 || lose !== 1'b0) begin
            bad++; $display("FAIL first_wait nd=%h round=%0d expected nd=%h round=1",
                            number_desired, round, exp_seq[0]);
        end
    endtask

    task automatic test_perfect_play();
        int errs;
        do_reset();
        ticks($urandom_range(1, 50));
        pulse_start();
        gen_phase(errs);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL play_gen errs=%0d expected 0", errs); end
        for (int r = 1; r <= MR; r++) begin
            show_phase(r, errs);
            total++;
            if (errs !== 0) begin bad++; $display("FAIL play_show r=%0d errs=%0d expected 0", r, errs); end
            for (int i = 0; i < r; i++) begin
                ticks($urandom_range(1, 4));
                total++;
                if (number_desired !== exp_seq[i] || lose !== 1'b0 || busy !== 1'b1) begin
                    bad++; $display("FAIL play_wait r=%0d i=%0d nd=%h lose=%b expected nd=%h lose=0",
                                    r, i, number_desired, lose, exp_seq[i]);
                end
                press(1'b1);
            end
        end
        total++;
        if (win !== 1'b1 || busy !== 1'b0 || display !== 6'h3F || round !== 4'd3 || lose !== 1'b0) begin
            bad++; $display("FAIL play_win win=%b busy=%b disp=%h round=%0d expected 1 0 3f 3",
                            win, busy, display, round);
        end
    endtask

    task automatic test_wrong_entry();
        int errs;
        pulse_start();
        total++;
        if (win !== 1'b0 || lose !== 1'b0 || round !== 4'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL wrong_restart win=%b lose=%b round=%0d busy=%b expected 0 0 1 1",
                            win, lose, round, busy);
        end
        gen_phase(errs);
        show_phase(1, errs);
        ticks($urandom_range(1, 4));
        press(1'b1);
        show_phase(2, errs);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL wrong_show2 errs=%0d expected 0", errs); end
        ticks($urandom_range(1, 4));
        press(1'b1);
        ticks($urandom_range(1, 4));
        total++;
        if (number_desired !== exp_seq[1]) begin
            bad++; $display("FAIL wrong_nd1 nd=%h expected %h", number_desired, exp_seq[1]);
        end
        press(1'b0);
        total++;
        if (lose !== 1'b1 || busy !== 1'b0 || display !== 6'd0 || win !== 1'b0) begin
            bad++; $display("FAIL wrong_lose lose=%b busy=%b disp=%h expected 1 0 0", lose, busy, display);
        end
        ticks(3);
        total++;
        if (lose !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL wrong_sticky lose=%b busy=%b expected 1 0", lose, busy);
        end
        pulse_start();
        total++;
        if (lose !== 1'b0 || round !== 4'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL wrong_restart2 lose=%b round=%0d busy=%b expected 0 1 1", lose, round, busy);
        end
    endtask

    task automatic test_timeout();
        int errs, stuck;
        do_reset();
        ticks($urandom_range(1, 30));
        pulse_start();
        gen_phase(errs);
        input_done = 1'b1; input_correct = 1'b1;
        show_phase(1, errs);
        stuck = 0;
        for (int k = 1; k <= TO; k++) begin
            if (lose !== 1'b0 || busy !== 1'b1 || number_desired !== exp_seq[0]) stuck++;
            tick();
        end
        total++;
        if (stuck !== 0) begin bad++; $display("FAIL hold_no_advance errs=%0d expected 0", stuck); end
        total++;
        if (lose !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_lose lose=%b busy=%b expected 1 0", lose, busy);
        end
        input_done = 1'b0; input_correct = 1'b0;
        // Held across WAIT entry, released, then a fresh press at WAIT cycle 10.
        pulse_start();
        gen_phase(errs);
        input_done = 1'b1; input_correct = 1'b1;
        show_phase(1, errs);
        ticks(4);
        total++;
        if (round !== 4'd1 || busy !== 1'b1 || number_desired !== exp_seq[0]) begin
            bad++; $display("FAIL hold_ignored round=%0d busy=%b expected 1 1", round, busy);
        end
        input_done = 1'b0; input_correct = 1'b0;
        ticks(5);
        press(1'b1);
        total++;
        if (round !== 4'd2 || busy !== 1'b1 || lose !== 1'b0 || display !== exp_seq[0]) begin
            bad++; $display("FAIL release_press round=%0d lose=%b disp=%h expected 2 0 %h",
                            round, lose, display, exp_seq[0]);
        end
        show_phase(2, errs);
        ticks(14);
        press(1'b1);
        ticks(14);
        total++;
        if (lose !== 1'b0 || busy !== 1'b1 || number_desired !== exp_seq[1]) begin
            bad++; $display("FAIL counter_restart lose=%b nd=%h expected 0 %h", lose, number_desired, exp_seq[1]);
        end
        press(1'b1);
        total++;
        if (round !== 4'd3 || busy !== 1'b1 || display !== exp_seq[0]) begin
            bad++; $display("FAIL round3_entry round=%0d disp=%h expected 3 %h", round, display, exp_seq[0]);
        end
    endtask

    task automatic test_late_press();
        int errs;
        start = 1'b1;
        show_phase(3, errs);
        start = 1'b0;
        total++;
        if (errs !== 0) begin bad++; $display("FAIL start_ignored errs=%0d expected 0", errs); end
        for (int i = 0; i < MR; i++) begin
            ticks(TO - 1);
            total++;
            if (lose !== 1'b0 || busy !== 1'b1 || number_desired !== exp_seq[i]) begin
                bad++; $display("FAIL late_wait i=%0d lose=%b nd=%h expected 0 %h", i, lose, number_desired, exp_seq[i]);
            end
            press(1'b1);
        end
        total++;
        if (win !== 1'b1 || lose !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL late_win win=%b lose=%b busy=%b expected 1 0 0", win, lose, busy);
        end
    endtask

    task automatic test_reset_midgame();
        int errs;
        do_reset();
        ticks($urandom_range(1, 30));
        pulse_start();
        gen_phase(errs);
        ticks(2);
        total++;
        if (display !== exp_seq[0]) begin
            bad++; $display("FAIL midgame_show disp=%h expected %h", display, exp_seq[0]);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        total++;
        if (outs !== 19'd0) begin bad++; $display("FAIL reset_in_show outs=%h expected 0", outs); end
        ticks(3);
        total++;
        if (outs !== 19'd0) begin bad++; $display("FAIL idle_after_reset outs=%h expected 0", outs); end
        pulse_start();
        gen_phase(errs);
        show_phase(1, errs);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL game_after_reset errs=%0d expected 0", errs); end
        ticks(3);
        reset = 1'b1; tick(); reset = 1'b0;
        total++;
        if (outs !== 19'd0) begin bad++; $display("FAIL reset_in_wait outs=%h expected 0", outs); end
        tick();
        total++;
        if (outs !== 19'd0) begin bad++; $display("FAIL idle_after_reset2 outs=%h expected 0", outs); end
    endtask

    task automatic test_seed_offset();
        int errs, a, b;
        logic [5:0] obs_a, obs_b;
        a = $urandom_range(2, 30);
        b = a + $urandom_range(1, 20);
        while (pat_of(lfsr_at(a + 1)) == pat_of(lfsr_at(b + 1))) b++;
        do_reset(); ticks(a); pulse_start(); gen_phase(errs);
        obs_a = display;
        total++;
        if (obs_a !== exp_seq[0]) begin bad++; $display("FAIL seed_a got=%h expected %h", obs_a, exp_seq[0]); end
        do_reset(); ticks(b); pulse_start(); gen_phase(errs);
        obs_b = display;
        total++;
        if (obs_b !== exp_seq[0]) begin bad++; $display("FAIL seed_b got=%h expected %h", obs_b, exp_seq[0]); end
        total++;
        if (obs_a === obs_b) begin
            bad++; $display("FAIL seed_differs a=%h b=%h expected different", obs_a, obs_b);
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_perfect_play();
        test_wrong_entry();
        test_timeout();
        test_late_press();
        test_reset_midgame();
        test_seed_offset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
